// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared types and constants for the configuration loader.
// Loader state encoding, default word width, 8x8 fabric chain length, clog2.
package fpga_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ldr_state_e;

  localparam int CFG_WORD_WIDTH   = 32;
  localparam int FABRIC_CHAIN_LEN = 4096;

  // Width needed to count 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/scan_piso.sv
// scan_piso: word-wide parallel-load / shift-right register, LSB first.
// Ports: clk_i, rst_ni (sync), load_i, shift_i, data_i -> bit_o, last_o.
module scan_piso
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_WIDTH = CFG_WORD_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  bit_o,
  output logic                  last_o
);

  localparam int IW = clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  bit_q, bit_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      idx_q <= '0;
      bit_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      bit_q <= bit_d;
    end
  end

  // bit_q is the bit on the wire; sh_q holds the bits still to come.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    bit_d = bit_q;
    if (load_i) begin
      bit_d = data_i[0];
      sh_d  = data_i >> 1;
      idx_d = '0;
    end else if (shift_i) begin
      bit_d = sh_q[0];
      sh_d  = sh_q >> 1;
      idx_d = idx_q + 1'b1;
    end
  end

  assign bit_o  = bit_q;
  assign last_o = (idx_q == IW'(WORD_WIDTH - 1));

endmodule

// File: rtl/scan_chain_loader.sv
// scan_chain_loader: streams config words LSB-first into the fabric scan chain.
// Ports: scan_clk/scan_rst_n, cfg_start, cfg_data/valid/ready, conn_scan_en/in/out,
// cfg_busy, cfg_done, rb_data/rb_valid. Optional readback: SCAN_READBACK_EN.
module scan_chain_loader
  import fpga_cfg_pkg::*;
#(
  parameter int WORD_WIDTH   = CFG_WORD_WIDTH,
  parameter int CHAIN_LENGTH = FABRIC_CHAIN_LEN
) (
  input  logic                  scan_clk,
  input  logic                  scan_rst_n,
  input  logic                  cfg_start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  conn_scan_en,
  output logic                  conn_scan_in,
  input  logic                  conn_scan_out,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);

  localparam int CW = clog2(CHAIN_LENGTH + 1);

  ldr_state_e    state_q, state_d;
  logic [CW-1:0] chain_left_q, chain_left_d;
  logic          scan_en_q, scan_en_d;
  logic          load, shift, accept;
  logic          last_bit, chain_end;

  assign accept    = cfg_valid & cfg_ready;
  // chain_left counts bits not yet put on the wire
  assign chain_end = (chain_left_q == '0);

  always_ff @(posedge scan_clk) begin
    if (!scan_rst_n) begin
      state_q      <= ST_IDLE;
      chain_left_q <= '0;
      scan_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      chain_left_q <= chain_left_d;
      scan_en_q    <= scan_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    chain_left_d = chain_left_q;
    scan_en_d    = scan_en_q;
    load         = 1'b0;
    shift        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d      = ST_LOAD;
          chain_left_d = CW'(CHAIN_LENGTH);
        end
      end
      ST_LOAD: begin
        if (accept) begin
          load         = 1'b1;
          scan_en_d    = 1'b1;
          state_d      = ST_SHIFT;
          chain_left_d = chain_left_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (chain_end) begin
          state_d   = ST_DONE;
          scan_en_d = 1'b0;
        end else if (!last_bit) begin
          shift        = 1'b1;
          chain_left_d = chain_left_q - 1'b1;
        end else if (accept) begin
          load         = 1'b1;
          chain_left_d = chain_left_q - 1'b1;
        end else begin
          state_d   = ST_LOAD;
          scan_en_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    cfg_busy  = 1'b0;
    cfg_done  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
      ST_SHIFT: begin
        cfg_ready = last_bit & ~chain_end;
        cfg_busy  = 1'b1;
      end
      ST_DONE: cfg_done = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  scan_piso #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_piso (
    .clk_i  (scan_clk),
    .rst_ni (scan_rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i (cfg_data),
    .bit_o  (conn_scan_in),
    .last_o (last_bit)
  );

  assign conn_scan_en = scan_en_q;

`ifdef SCAN_READBACK_EN
  localparam int IW = clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] rb_sh_q, rb_data_q, rb_word;
  logic [IW-1:0]         rb_cnt_q;
  logic                  rb_valid_q, rb_flush;

  assign rb_word  = rb_sh_q | (WORD_WIDTH'(conn_scan_out) << rb_cnt_q);
  // flush on a full word or on the final bit of the load
  assign rb_flush = (rb_cnt_q == IW'(WORD_WIDTH - 1)) || chain_end;

  always_ff @(posedge scan_clk) begin
    if (!scan_rst_n) begin
      rb_sh_q    <= '0;
      rb_data_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (state_q == ST_IDLE && cfg_start) begin
        rb_sh_q  <= '0;
        rb_cnt_q <= '0;
      end else if (scan_en_q) begin
        if (rb_flush) begin
          rb_valid_q <= 1'b1;
          rb_data_q  <= rb_word;
          rb_sh_q    <= '0;
          rb_cnt_q   <= '0;
        end else begin
          rb_sh_q  <= rb_word;
          rb_cnt_q <= rb_cnt_q + 1'b1;
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic rb_unused;
  assign rb_unused = conn_scan_out;
  assign rb_data   = '0;
  assign rb_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb_scan_chain_loader: scoreboard bench for scan_chain_loader.
// Two instances: A (chain 64) and B (chain 40), sharing data/valid/reset.
module tb_scan_chain_loader;

  localparam int W = 32;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, valid, start_a, start_b, sel_b, dl_init;
  logic [W-1:0] data;

  logic         a_ready, a_en, a_in, a_busy, a_done, a_rbv, a_sout;
  logic         b_ready, b_en, b_in, b_busy, b_done, b_rbv;
  logic [W-1:0] a_rbd, b_rbd;
  logic [31:0]  dl;

  scan_chain_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(64)) u_a (
    .scan_clk(clk), .scan_rst_n(rst_n), .cfg_start(start_a),
    .cfg_data(data), .cfg_valid(valid), .cfg_ready(a_ready),
    .conn_scan_en(a_en), .conn_scan_in(a_in), .conn_scan_out(a_sout),
    .cfg_busy(a_busy), .cfg_done(a_done), .rb_data(a_rbd), .rb_valid(a_rbv)
  );

  scan_chain_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(40)) u_b (
    .scan_clk(clk), .scan_rst_n(rst_n), .cfg_start(start_b),
    .cfg_data(data), .cfg_valid(valid), .cfg_ready(b_ready),
    .conn_scan_en(b_en), .conn_scan_in(b_in), .conn_scan_out(1'b0),
    .cfg_busy(b_busy), .cfg_done(b_done), .rb_data(b_rbd), .rb_valid(b_rbv)
  );

  // 32-bit chain model behind instance A
  assign a_sout = dl[0];
  always @(posedge clk)
    if (dl_init) dl <= 32'h1234_5678;
    else if (a_en) dl <= {a_in, dl[31:1]};

  logic m_ready, m_en, m_in, m_busy, m_done, m_rbv;
  logic [W-1:0] m_rbd;
  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_en    = sel_b ? b_en    : a_en;
  assign m_in    = sel_b ? b_in    : a_in;
  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_rbv   = sel_b ? b_rbv   : a_rbv;
  assign m_rbd   = sel_b ? b_rbd   : a_rbd;

  int checks = 0;
  int errors = 0;
  int exp_left = 0;
  bit exp_q[$];
  bit obs_q[$];
  logic [W-1:0] rb_q[$];

  int clr_seq = 0, seen_seq = 0, cyc = 0;
  int en_cnt = 0, gap_cnt = 0, done_cnt = 0, ready_cnt = 0, rbv_cnt = 0;
  int last_en_cyc = 0, done_cyc = 0;
  bit seen_en = 0;

  always @(negedge clk) begin
    cyc++;
    if (clr_seq != seen_seq) begin
      seen_seq = clr_seq;
      obs_q.delete();
      rb_q.delete();
      en_cnt = 0; gap_cnt = 0; done_cnt = 0;
      ready_cnt = 0; rbv_cnt = 0; seen_en = 0;
      last_en_cyc = 0; done_cyc = 0;
    end
    if (m_en) begin
      obs_q.push_back(m_in);
      en_cnt++;
      last_en_cyc = cyc;
      seen_en = 1;
    end else if (seen_en && m_busy) begin
      gap_cnt++;
    end
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_ready) ready_cnt++;
    if (m_rbv) begin
      rbv_cnt++;
      rb_q.push_back(m_rbd);
    end
  end

  task automatic new_load();
    @(posedge clk); #1;
    clr_seq++;
    exp_q.delete();
    exp_left = sel_b ? 40 : 64;
  endtask

  task automatic pulse_start();
    if (sel_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] w, input int gap);
    bit ok;
    int n;
    if (gap > 0) begin
      valid = 1'b0;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (m_ready) begin ok = 1; break; end
      end
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL gap_ready_timeout got ready=0 want ready=1");
      end
      repeat (gap) @(posedge clk);
      #1;
    end
    data  = w;
    valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_ready) begin ok = 1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout word %h got ready=0 want ready=1", w);
    end else begin
      n = (exp_left < W) ? exp_left : W;
      for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
      exp_left -= n;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=0 want done=1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_en, a_in, a_ready, a_busy, a_done, a_rbv} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a_ctl got %b want 000000",
               {a_en, a_in, a_ready, a_busy, a_done, a_rbv});
    end
    checks++;
    if ({b_en, b_in, b_ready, b_busy, b_done, b_rbv} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b_ctl got %b want 000000",
               {b_en, b_in, b_ready, b_busy, b_done, b_rbv});
    end
    checks++;
    if (a_rbd !== '0 || b_rbd !== '0) begin
      errors++;
      $display("FAIL reset_rbd got %h/%h want 0", a_rbd, b_rbd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sel_b = 1'b0;
    new_load();
    pulse_start();
    feed(32'hA5A5_0001, 0);
    feed(32'h8000_FFFF, 0);
    wait_done();
    checks++;
    if (m_busy !== 1'b0 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_busy got busy=%b ready=%b want 0/0", m_busy, m_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (en_cnt != 64 || gap_cnt != 0) begin
      errors++;
      $display("FAIL basic_en got %0d/%0d want 64/0", en_cnt, gap_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_en_cyc + 1) begin
      errors++;
      $display("FAIL basic_done got cnt=%0d at %0d want 1 at %0d",
               done_cnt, done_cyc, last_en_cyc + 1);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      bit b = exp_q.pop_front();
      checks++;
      if (obs_q[i] !== b) begin
        errors++;
        $display("FAIL basic_bit%0d got %b want %b", i, obs_q[i], b);
      end
    end
  endtask

  task automatic test_partial();
    int r0;
    sel_b = 1'b1;
    new_load();
    pulse_start();
    feed(32'hFFFF_FFFF, 0);
    feed(32'h0000_00F3, 0);
    r0 = ready_cnt;
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (en_cnt != 40 || done_cnt != 1) begin
      errors++;
      $display("FAIL partial_en got %0d/%0d want 40/1", en_cnt, done_cnt);
    end
    checks++;
    if (ready_cnt != r0) begin
      errors++;
      $display("FAIL partial_ready got %0d want %0d", ready_cnt, r0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL partial_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      bit b = exp_q.pop_front();
      checks++;
      if (obs_q[i] !== b) begin
        errors++;
        $display("FAIL partial_bit%0d got %b want %b", i, obs_q[i], b);
      end
    end
    sel_b = 1'b0;
  endtask

  task automatic test_gap();
    sel_b = 1'b0;
    new_load();
    pulse_start();
    feed(32'h1357_9BDF, 0);
    feed(32'h2468_ACE0, 5);
    wait_done();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (en_cnt != 64 || gap_cnt != 5) begin
      errors++;
      $display("FAIL gap_en got %0d/%0d want 64/5", en_cnt, gap_cnt);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gap_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      bit b = exp_q.pop_front();
      checks++;
      if (obs_q[i] !== b) begin
        errors++;
        $display("FAIL gap_bit%0d got %b want %b", i, obs_q[i], b);
      end
    end
  endtask

  task automatic test_start_mid();
    sel_b = 1'b0;
    new_load();
    pulse_start();
    feed(32'hC001_D00D, 0);
    repeat (8) @(posedge clk);
    #1;
    pulse_start();
    feed(32'h7E57_0042, 0);
    wait_done();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done got busy=%b want 0", m_busy);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (en_cnt != 64 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_mid_en got %0d/%0d want 64/1", en_cnt, done_cnt);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL start_mid_len got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      bit b = exp_q.pop_front();
      checks++;
      if (obs_q[i] !== b) begin
        errors++;
        $display("FAIL start_mid_bit%0d got %b want %b", i, obs_q[i], b);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sel_b = 1'b0;
    new_load();
    pulse_start();
    feed(32'h5555_AAAA, 0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (en_cnt >= 17) begin ok = 1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_timeout got en_cnt=%0d want 17", en_cnt);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_en, m_busy, m_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_state got %b want 000", {m_en, m_busy, m_ready});
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_done got %0d want 0", done_cnt);
    end
    new_load();
    pulse_start();
    feed(32'h0F0F_3C3C, 0);
    feed(32'hDEAD_BEEF, 0);
    wait_done();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (en_cnt != 64 || done_cnt != 1) begin
      errors++;
      $display("FAIL rst_reload_en got %0d/%0d want 64/1", en_cnt, done_cnt);
    end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      bit b = exp_q.pop_front();
      checks++;
      if (obs_q[i] !== b) begin
        errors++;
        $display("FAIL rst_reload_bit%0d got %b want %b", i, obs_q[i], b);
      end
    end
  endtask

  task automatic test_readback();
    sel_b = 1'b0;
    new_load();
    dl_init = 1'b1;
    @(posedge clk); #1;
    dl_init = 1'b0;
    pulse_start();
    feed(32'hA5A5_0001, 0);
    feed(32'h8000_FFFF, 0);
    wait_done();
    repeat (3) @(negedge clk);
    #1;
`ifdef SCAN_READBACK_EN
    checks++;
    if (rbv_cnt != 2) begin
      errors++;
      $display("FAIL rb_count got %0d want 2", rbv_cnt);
    end
    checks++;
    if (rb_q.size() < 1 || rb_q[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rb_word0 got %h want 12345678",
               (rb_q.size() > 0) ? rb_q[0] : 32'hx);
    end
    checks++;
    if (rb_q.size() < 2 || rb_q[1] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL rb_word1 got %h want a5a50001",
               (rb_q.size() > 1) ? rb_q[1] : 32'hx);
    end
`else
    checks++;
    if (rbv_cnt != 0 || m_rbd !== '0) begin
      errors++;
      $display("FAIL rb_off got %0d/%h want 0/0", rbv_cnt, m_rbd);
    end
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    data    = '0;
    start_a = 1'b0;
    start_b = 1'b0;
    sel_b   = 1'b0;
    dl_init = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_gap();
    test_start_mid();
    test_reset_mid();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
